// File: rtl/sum_uart_tx.sv
// sum_uart_tx: FIFO-buffered UART transmitter for the adder's 8-bit sums (8N1).
// Define SUM_TX_PARITY_EN to add an even parity bit (8E1 frames).
module sum_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SUM_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // ---------------- FIFO ----------------
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, empty, push, pop;

  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is left out of reset; occupancy decides what is valid, and
  // an unreset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  assign fifo_count = count;

  // ---------------- Transmit FSM ----------------
  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        data_q, data_d;
  logic              tx_q, tx_d;
  logic              baud_wrap;

  assign baud_wrap = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    data_d  = data_q;
    tx_d    = tx_q;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          data_d  = mem[rd_ptr];
          bit_d   = '0;
          baud_d  = '0;
          tx_d    = 1'b0;
          state_d = START;
        end
      end

      START: begin
        if (baud_wrap) begin
          baud_d  = '0;
          tx_d    = data_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      DATA: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef SUM_TX_PARITY_EN
            tx_d    = ^data_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = data_q[bit_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

`ifdef SUM_TX_PARITY_EN
      PARITY: begin
        if (baud_wrap) begin
          baud_d  = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif

      STOP: begin
        if (baud_wrap) begin
          baud_d = '0;
          // Back-to-back: the next start bit begins on this very edge.
          if (!empty) begin
            pop     = 1'b1;
            data_d  = mem[rd_ptr];
            bit_d   = '0;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_sum_uart_tx.sv
// tb_sum_uart_tx: directed tables, corner sequences and random traffic checked
// against a queue-and-frame-position model of the transmitter.
module tb_sum_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef SUM_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready, tx, busy;
  logic [CW-1:0] fifo_count;

  sum_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: queue of accepted bytes plus position inside current frame.
  logic [7:0] q[$];
  bit         m_active = 1'b0;
  int         m_pos    = 0;
  logic [7:0] m_cur    = 8'h00;
  bit         m_pushed = 1'b0;

  typedef struct {
    int   cyc;
    logic exp_tx;
    logic exp_busy;
    int   exp_cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_edge();
    bit ready;
    bit have;
    ready    = q.size() < DEPTH;
    have     = q.size() > 0;
    m_pushed = 1'b0;
    if (!rst_n) begin
      q.delete();
      m_active = 1'b0;
      m_pos    = 0;
      return;
    end
    if (m_active && m_pos != FRAME - 1) m_pos++;
    else if (have) begin
      m_cur    = q.pop_front();
      m_pos    = 0;
      m_active = 1'b1;
    end else m_active = 1'b0;
    if (in_valid && ready) begin
      q.push_back(in_data);
      m_pushed = 1'b1;
    end
  endfunction

  function automatic logic exp_tx();
    int b;
    if (!m_active) return 1'b1;
    b = m_pos / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
    if (b == NBITS - 1) return 1'b1;
    return ^m_cur;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("tx", tx, exp_tx());
    check("busy", busy, m_active);
    check("fifo_count", fifo_count, q.size());
    check("in_ready", in_ready, q.size() < DEPTH);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic void add_vec(input int c, input logic t, input logic b, input int n);
    vec_t v;
    v.cyc = c; v.exp_tx = t; v.exp_busy = b; v.exp_cnt = n;
    tbl.push_back(v);
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] full_bytes [6];
    int ss, idx, k;

    // ---- Reset ----
    rst_n = 1'b0;
    run(2);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_count", fifo_count, 0);
    rst_n = 1'b1;
    run(2);

    // ---- Ignored write ----
    in_valid = 1'b0;
    in_data  = 8'hAA;
    for (int i = 0; i < 20; i++) begin
      step();
      check("ignored_tx", tx, 1);
      check("ignored_count", fifo_count, 0);
    end

    // ---- Single byte 0xA5 (table-driven) ----
    ss = 1 + CPB * (NBITS - 1);
    add_vec(0, 1'b1, 1'b0, 1);
    add_vec(1, 1'b0, 1'b1, 0);
    add_vec(4, 1'b0, 1'b1, 0);
    add_vec(5, 1'b1, 1'b1, 0);
    add_vec(9, 1'b0, 1'b1, 0);
    add_vec(13, 1'b1, 1'b1, 0);
    add_vec(17, 1'b0, 1'b1, 0);
    add_vec(21, 1'b0, 1'b1, 0);
    add_vec(25, 1'b1, 1'b1, 0);
    add_vec(29, 1'b0, 1'b1, 0);
    add_vec(33, 1'b1, 1'b1, 0);
    add_vec(36, 1'b1, 1'b1, 0);
`ifdef SUM_TX_PARITY_EN
    add_vec(37, 1'b0, 1'b1, 0);
`endif
    add_vec(ss, 1'b1, 1'b1, 0);
    add_vec(ss + 3, 1'b1, 1'b1, 0);
    add_vec(ss + 4, 1'b1, 1'b0, 0);
    for (int c = 0; c <= ss + 4; c++) begin
      if (c == 0) begin
        in_valid = 1'b1;
        in_data  = 8'hA5;
        step();
        in_valid = 1'b0;
      end else step();
      foreach (tbl[i]) begin
        if (tbl[i].cyc == c) begin
          check($sformatf("a5_tx_c%0d", c), tx, tbl[i].exp_tx);
          check($sformatf("a5_busy_c%0d", c), busy, tbl[i].exp_busy);
          check($sformatf("a5_count_c%0d", c), fifo_count, tbl[i].exp_cnt);
        end
      end
    end
    run(3);

    // ---- Back-to-back 0x01, 0x80, 0xFF ----
    in_valid = 1'b1;
    in_data = 8'h01; step(); check("b2b_count0", fifo_count, 1);
    in_data = 8'h80; step(); check("b2b_count1", fifo_count, 1);
    in_data = 8'hFF; step(); check("b2b_count2", fifo_count, 2);
    in_valid = 1'b0;
    run(FRAME - 2);
    check("b2b_stop1_tx", tx, 1);
    check("b2b_stop1_count", fifo_count, 2);
    run(1);
    check("b2b_start2_tx", tx, 0);
    check("b2b_start2_busy", busy, 1);
    check("b2b_start2_count", fifo_count, 1);
    run(FRAME);
    check("b2b_start3_tx", tx, 0);
    check("b2b_start3_count", fifo_count, 0);
    run(FRAME);
    check("b2b_end_busy", busy, 0);
    check("b2b_end_tx", tx, 1);
    run(3);

    // ---- Full FIFO with six bytes ----
    full_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    idx = 0;
    k = 0;
    in_valid = 1'b1;
    while (idx < 6 && k < 200) begin
      in_data = full_bytes[idx];
      step();
      k++;
      if (m_pushed) idx++;
      if (k == 5) begin
        check("full_in_ready", in_ready, 0);
        check("full_count", fifo_count, 4);
      end
    end
    in_valid = 1'b0;
    check("full_6th_accept_cycle", k, FRAME + 3);
    run(6 * FRAME + 10);
    check("full_drain_busy", busy, 0);

    // ---- Reset mid-frame ----
    in_valid = 1'b1;
    in_data = 8'h3C; step();
    in_data = 8'h11; step();
    in_data = 8'h22; step();
    in_valid = 1'b0;
    run(15);
    check("rstmid_bit3_tx", tx, 1);
    check("rstmid_queued", fifo_count, 2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rstmid_tx", tx, 1);
    check("rstmid_busy", busy, 0);
    check("rstmid_count", fifo_count, 0);
    run(3 * FRAME);
    check("rstmid_quiet_busy", busy, 0);
    check("rstmid_quiet_tx", tx, 1);

`ifdef SUM_TX_PARITY_EN
    // ---- Parity frames ----
    in_valid = 1'b1; in_data = 8'h07; step(); in_valid = 1'b0;
    run(37);
    check("par07_bit", tx, 1);
    run(7);
    check("par07_busy_last", busy, 1);
    run(1);
    check("par07_busy_end", busy, 0);
    in_valid = 1'b1; in_data = 8'h03; step(); in_valid = 1'b0;
    run(37);
    check("par03_bit", tx, 0);
    run(10);
`endif

    // ---- Random traffic ----
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom);
      rst_n    = ($urandom_range(0, 1499) != 0);
      step();
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    run((DEPTH + 2) * FRAME + 10);
    check("final_idle_busy", busy, 0);
    check("final_idle_count", fifo_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
